// File: rtl/aes_enc_iter.sv
// aes_enc_iter: iterative AES-128 encryption engine.
// ROUNDS_PER_CYCLE chained rounds are applied per RUN cycle (legal: 1, 2, 5, 10).
// Valid/ready handshake on the input and output sides; the output side honours backpressure.
// Optional build macro AES_ZEROIZE_EN: the key, the state and the ciphertext are cleared on the
// output handshake, so the ciphertext reads zero whenever out_valid is low.

package aes_enc_iter_pkg;

    // Forward S-box; byte value b is stored at bits [2047-8*b -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// Combinational key expansion: round key k sits at roundkeys_o[1407-128*k -: 128].
module aes_key_expand
    import aes_enc_iter_pkg::*;
(
    input  logic [127:0]  key_i,
    output logic [1407:0] roundkeys_o
);

    logic [31:0] w_s [0:43];
    logic [31:0] tmp_s;

    // Expand the cipher key into 44 words, then pack them MSB-first.
    always_comb begin
        tmp_s       = 32'h0;
        roundkeys_o = 1408'h0;
        for (int i = 0; i < 4; i++) begin
            w_s[i] = key_i[127 - 32*i -: 32];
        end
        for (int i = 4; i < 44; i++) begin
            tmp_s  = w_s[i-1];
            w_s[i] = w_s[i-4] ^ (((i % 4) == 0)
                     ? (sub_word({tmp_s[23:0], tmp_s[31:24]}) ^ {rcon(4'(i / 4)), 24'h000000})
                     : tmp_s);
        end
        for (int i = 0; i < 44; i++) begin
            roundkeys_o[1407 - 32*i -: 32] = w_s[i];
        end
    end

endmodule

// One AES encryption round; MixColumns is skipped when last_i is set.
module aes_round_enc
    import aes_enc_iter_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         last_i,
    output logic [127:0] state_o
);

    // Byte n of the state is bits [127-8n -: 8]; row r, column c is byte r+4c.
    logic [7:0] sb_s [0:15];
    logic [7:0] sr_s [0:15];
    logic [7:0] mc_s [0:15];

    // SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
    always_comb begin
        state_o = 128'h0;
        for (int i = 0; i < 16; i++) begin
            sb_s[i] = sbox(state_i[127 - 8*i -: 8]);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                sr_s[r + 4*c] = sb_s[r + 4*((c + r) % 4)];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc_s[4*c]   = xtime(sr_s[4*c]) ^ xtime(sr_s[4*c+1]) ^ sr_s[4*c+1]
                          ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c+1] = sr_s[4*c] ^ xtime(sr_s[4*c+1]) ^ xtime(sr_s[4*c+2])
                          ^ sr_s[4*c+2] ^ sr_s[4*c+3];
            mc_s[4*c+2] = sr_s[4*c] ^ sr_s[4*c+1] ^ xtime(sr_s[4*c+2])
                          ^ xtime(sr_s[4*c+3]) ^ sr_s[4*c+3];
            mc_s[4*c+3] = xtime(sr_s[4*c]) ^ sr_s[4*c] ^ sr_s[4*c+1]
                          ^ sr_s[4*c+2] ^ xtime(sr_s[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            state_o[127 - 8*i -: 8] = (last_i ? sr_s[i] : mc_s[i]) ^ rkey_i[127 - 8*i -: 8];
        end
    end

endmodule

module aes_enc_iter #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic         busy
);

    if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
          ROUNDS_PER_CYCLE == 5 || ROUNDS_PER_CYCLE == 10)) begin : g_bad_rpc
        $error("aes_enc_iter: ROUNDS_PER_CYCLE must be 1, 2, 5 or 10");
    end else begin : g_ok_rpc
    end

    localparam logic [3:0] RSTEP = 4'(ROUNDS_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    fsm_e          fsm_q, fsm_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q, busy_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [127:0]  state_q, state_d;
    logic [127:0]  key_q, key_d;
    logic [127:0]  ct_q, ct_d;

    logic [1407:0] rk_s;
    logic [127:0]  run_result_s;
    logic [3:0]    rnd_next_s;
    logic          rnd_last_s;

    assign rnd_next_s = rnd_q + RSTEP;
    assign rnd_last_s = (rnd_next_s == 4'd10);

    aes_key_expand u_key_expand (
        .key_i       (key_q),
        .roundkeys_o (rk_s)
    );

    // Round chain: stage j applies round rnd_q+j+1; its input is the previous stage's output.
    for (genvar j = 0; j < ROUNDS_PER_CYCLE; j++) begin : g_stage
        logic [3:0]   idx_s;
        logic [127:0] in_s;
        logic [127:0] out_s;
        logic [127:0] rkey_s;

        assign idx_s  = rnd_q + 4'(j + 1);
        assign rkey_s = (idx_s <= 4'd10) ? rk_s[11'd1407 - {idx_s, 7'd0} -: 128] : 128'h0;

        if (j == 0) begin : g_first
            assign in_s = state_q;
        end else begin : g_next
            assign in_s = g_stage[j-1].out_s;
        end

        aes_round_enc u_round (
            .state_i (in_s),
            .rkey_i  (rkey_s),
            .last_i  (idx_s == 4'd10),
            .state_o (out_s)
        );
    end

    assign run_result_s = g_stage[ROUNDS_PER_CYCLE-1].out_s;

    // FSM state register together with the registered handshake/status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm_q       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: accept in IDLE, leave RUN after round 10, leave DONE on handshake.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    fsm_d = ST_RUN;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rnd_last_s) begin
                    fsm_d = ST_DONE;
                end else begin
                    fsm_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end else begin
                    fsm_d = ST_DONE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered.
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (fsm_d)
            ST_IDLE: begin
                in_ready_d = 1'b1;
            end
            ST_RUN: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: begin
                in_ready_d = 1'b1;
            end
        endcase
    end

    // Datapath next values: load round 0, iterate, capture the result, optionally zeroize.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        ct_d    = ct_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    key_d   = key;
                    state_d = plaintext ^ key;
                    rnd_d   = 4'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RUN: begin
                state_d = run_result_s;
                rnd_d   = rnd_next_s;
                if (rnd_last_s) begin
                    ct_d = run_result_s;
                end else begin
                    ct_d = ct_q;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
`ifdef AES_ZEROIZE_EN
                    key_d   = 128'h0;
                    state_d = 128'h0;
                    ct_d    = 128'h0;
`else
                    ct_d    = ct_q;
`endif
                end else begin
                    ct_d = ct_q;
                end
            end
            default: begin
                rnd_d = 4'd0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= 128'h0;
            key_q   <= 128'h0;
            rnd_q   <= 4'd0;
            ct_q    <= 128'h0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            ct_q    <= ct_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Testbench for aes_enc_iter: known-answer vectors, latency, backpressure, back-to-back,
// mid-block reset and randomized blocks checked against a byte-level AES model.
module tb_aes_enc_iter;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] pt, key, ct;

    logic         in_valid_a, out_ready_a;
    logic [127:0] pt_a, key_a;
    logic         in_ready_a  [3];
    logic         out_valid_a [3];
    logic         busy_a      [3];
    logic [127:0] ct_a        [3];

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] sbox_t [256];

    always #5 clk = ~clk;

    aes_enc_iter #(.ROUNDS_PER_CYCLE(1)) dut (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(pt), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ct), .busy(busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_aux
        aes_enc_iter #(.ROUNDS_PER_CYCLE(g == 0 ? 2 : (g == 1 ? 5 : 10))) u_aux (
            .CLK(clk), .RST(rst), .in_valid(in_valid_a), .in_ready(in_ready_a[g]),
            .plaintext(pt_a), .key(key_a), .out_valid(out_valid_a[g]),
            .out_ready(out_ready_a), .ciphertext(ct_a[g]), .busy(busy_a[g])
        );
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] b;
            logic [7:0] inv;
            b   = 8'(v);
            inv = 8'h00;
            if (b != 8'h00) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, b);
            end
            sbox_t[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                        ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_model(input logic [127:0] pt_v, input logic [127:0] key_v);
        logic [7:0] rk [176];
        logic [7:0] s  [16];
        logic [7:0] t  [16];
        logic [7:0] w  [4];
        logic [7:0] col [4];
        logic [7:0] tmp;
        logic [7:0] rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key_v[127 - 8*i -: 8];
            s[i]  = pt_v[127 - 8*i -: 8] ^ rk[i];
        end
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) w[j] = rk[4*(i-1) + j];
            if (i % 4 == 0) begin
                tmp  = w[0];
                w[0] = sbox_t[w[1]] ^ rc;
                w[1] = sbox_t[w[2]];
                w[2] = sbox_t[w[3]];
                w[3] = sbox_t[tmp];
                rc   = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) rk[4*i + j] = rk[4*(i-4) + j] ^ w[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
            for (int row = 0; row < 4; row++)
                for (int c = 0; c < 4; c++)
                    s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++) col[row] = s[4*c + row];
                    for (int row = 0; row < 4; row++)
                        s[4*c + row] = gmul(8'h02, col[row]) ^ gmul(8'h03, col[(row+1)%4])
                                       ^ col[(row+2)%4] ^ col[(row+3)%4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- checkers ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one block for a single edge, then scramble the inputs.
    task automatic send(input logic [127:0] p, input logic [127:0] k);
        chk1("send_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; pt = p; key = k;
        tick();
        in_valid = 1'b0;
        pt  = {$urandom, $urandom, $urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        chk1("run_in_ready", in_ready, 1'b0);
        chk1("run_busy", busy, 1'b1);
    endtask

    // Latency = edges from the accepting edge to the first edge that samples out_valid high.
    task automatic wait_valid(input int max_edges, output int lat);
        int edges;
        edges = 0;
        while (out_valid !== 1'b1 && edges < max_edges) begin
            tick();
            edges++;
        end
        lat = edges + 1;
    endtask

    task automatic run_block(input logic [127:0] p, input logic [127:0] k,
                             input logic [127:0] exp, input int hold, input bit pulse);
        int lat;
        send(p, k);
        wait_valid(30, lat);
        chk_int("latency_r1", lat, 11);
        chk("ct", ct, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
            pt  = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            tick();
            chk("bp_ct_stable", ct, exp);
            chk1("bp_out_valid", out_valid, 1'b1);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk1("hs_out_valid", out_valid, 1'b0);
        chk1("hs_in_ready", in_ready, 1'b1);
        chk1("hs_busy", busy, 1'b0);
`ifdef AES_ZEROIZE_EN
        chk("zeroize_ct", ct, 128'h0);
        chk("zeroize_key_q", dut.key_q, 128'h0);
        chk("zeroize_state_q", dut.state_q, 128'h0);
`else
        chk("retain_ct", ct, exp);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] p;
        logic [127:0] k;
        logic [127:0] hs_q [$];
        logic [127:0] ct_now;
        logic [127:0] ct_got [3];
        int           lat_a [3];
        int           acc_t [2];
        int           acc_n;
        logic         acc, hs;

        build_sbox();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; pt = 128'h0; key = 128'h0;
        in_valid_a = 1'b0; out_ready_a = 1'b1; pt_a = 128'h0; key_a = 128'h0;
        repeat (3) tick();
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk("rst_ct", ct, 128'h0);
        for (int g = 0; g < 3; g++) chk1("rst_aux_in_ready", in_ready_a[g], 1'b1);
        rst = 1'b0;
        tick();

        // FIPS-197 App.B at R=1, then App.C.1 at R=1.
        run_block(PT_B, KEY_B, CT_B, 0, 1'b0);
        chk("model_b", aes_model(PT_B, KEY_B), CT_B);
        run_block(PT_C, KEY_C, CT_C, 2, 1'b0);

        // App.C.1 on the R=2/5/10 instances (they hand off immediately, out_ready tied high).
        in_valid_a = 1'b1; pt_a = PT_C; key_a = KEY_C;
        tick();
        in_valid_a = 1'b0; pt_a = 128'h0; key_a = 128'h0;
        for (int g = 0; g < 3; g++) begin lat_a[g] = 99; ct_got[g] = 128'h0; end
        for (int e = 1; e <= 15; e++) begin
            tick();
            for (int g = 0; g < 3; g++) begin
                if (lat_a[g] == 99 && out_valid_a[g] === 1'b1) begin
                    lat_a[g]  = e + 1;
                    ct_got[g] = ct_a[g];
                end
            end
        end
        chk_int("latency_r2", lat_a[0], 6);
        chk_int("latency_r5", lat_a[1], 3);
        chk_int("latency_r10", lat_a[2], 2);
        for (int g = 0; g < 3; g++) begin
            chk("aux_ct", ct_got[g], CT_C);
            chk1("aux_idle", busy_a[g], 1'b0);
        end

        // Backpressure: 20 cycles of out_ready=0 with stray in_valid pulses.
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        run_block(p, k, aes_model(p, k), 20, 1'b1);

        // Back-to-back App.B then App.C.1 with out_ready held high.
        in_valid = 1'b1; pt = PT_B; key = KEY_B; out_ready = 1'b1;
        acc_n = 0; acc_t[0] = 0; acc_t[1] = 0;
        for (int c = 0; c < 40 && hs_q.size() < 2; c++) begin
            acc = in_valid & in_ready;
            hs  = out_valid & out_ready;
            ct_now = ct;
            tick();
            if (hs) hs_q.push_back(ct_now);
            if (acc) begin
                if (acc_n < 2) acc_t[acc_n] = c;
                acc_n++;
                if (acc_n == 1) begin pt = PT_C; key = KEY_C; end
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk_int("b2b_accepts", acc_n, 2);
        chk_int("b2b_spacing", acc_t[1] - acc_t[0], 12);
        chk_int("b2b_outputs", hs_q.size(), 2);
        while (hs_q.size() < 2) hs_q.push_back(128'h0);
        chk("b2b_first", hs_q[0], CT_B);
        chk("b2b_second", hs_q[1], CT_C);

        // Reset in the middle of RUN at rnd=5, then a clean block.
        send(PT_C, KEY_C);
        repeat (5) tick();
        chk_int("mid_rnd", int'(dut.rnd_q), 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("abort_in_ready", in_ready, 1'b1);
        chk1("abort_out_valid", out_valid, 1'b0);
        chk1("abort_busy", busy, 1'b0);
        chk("abort_ct", ct, 128'h0);
        run_block(PT_C, KEY_C, CT_C, 0, 1'b0);

        // Randomized blocks with random backpressure against the model.
        for (int n = 0; n < 12; n++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk1("idle_out_ready_noeffect", out_valid, 1'b0);
            run_block(p, k, aes_model(p, k), int'($urandom_range(0, 3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
